// File: rtl/uart_pkg.sv
// Shared UART types: line-control register layout, per-frame receive config,
// receiver state encoding and the parity helper.
package uart_pkg;

    typedef struct packed {
        logic       dlab;
        logic       set_break;
        logic       stick_parity;
        logic       eps;
        logic       pen;
        logic       stb;
        logic [1:0] wls;
    } lcr_t;

    // Subset of the LCR the receiver needs, frozen for the duration of one character.
    typedef struct packed {
        logic       stick;
        logic       eps;
        logic       pen;
        logic [1:0] wls;
    } rx_cfg_t;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE     = 3'd0;
    localparam rx_state_t ST_START    = 3'd1;
    localparam rx_state_t ST_DATA     = 3'd2;
    localparam rx_state_t ST_PARITY   = 3'd3;
    localparam rx_state_t ST_STOP     = 3'd4;
    localparam rx_state_t ST_BRK_WAIT = 3'd5;

    localparam int RX_OVERSAMPLE   = 16;
    localparam int RX_SAMPLE_POINT = 7;
    localparam int RX_SYNC_STAGES  = 2;

    // Parity bit the transmitter should have sent; unused data MSBs must be zero.
    function automatic logic rx_parity(input logic [7:0] data, input logic stick, input logic eps);
        if (stick) return ~eps;
        return eps ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous RX pin; resets to the idle-high line level.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= sync_d;
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive engine: oversampled deframing of rx_i into characters with PE/FE/BI status,
// pushed into the RX FIFO, with an overrun pulse when the FIFO cannot take the character.
//
// state    | meaning
// IDLE     | line idle, watching for a falling edge on a tick
// START    | confirming the start bit at mid-bit
// DATA     | sampling wls+5 data bits, LSB first
// PARITY   | sampling and checking the parity bit
// STOP     | sampling the first stop bit, pushing or flagging overrun
// BRK_WAIT | stop bit was 0, waiting for the line to return high
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE   = RX_OVERSAMPLE,
    parameter int SAMPLE_POINT = RX_SAMPLE_POINT,
    parameter int SYNC_STAGES  = RX_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse_i,
    input  logic       rx_i,
    input  lcr_t       lcr_i,
    input  logic       rx_fifo_full_i,
    output logic       push_o,
    output logic [7:0] dout_o,
    output logic       pe_o,
    output logic       fe_o,
    output logic       bi_o,
    output logic       oe_o,
    output logic       busy_o
);

    localparam int TICK_W = $clog2(OVERSAMPLE);

    logic rx_s;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (rx_s)
    );

    rx_state_t         state_q,   state_d;
    logic [TICK_W-1:0] tick_q,    tick_d;
    logic [2:0]        bit_q,     bit_d;
    logic [7:0]        data_q,    data_d;
    rx_cfg_t           cfg_q,     cfg_d;
    logic              ones_q,    ones_d;
    logic              par_err_q, par_err_d;
    logic              rx_prev_q, rx_prev_d;
    logic              push_q,    push_d;
    logic              oe_q,      oe_d;
    logic [7:0]        dout_q,    dout_d;
    logic              pe_q,      pe_d;
    logic              fe_q,      fe_d;
    logic              bi_q,      bi_d;

    logic bit_tc;
    logic last_bit;
    logic unused_lcr;

    assign unused_lcr = ^{lcr_i.dlab, lcr_i.set_break, lcr_i.stb};
    assign bit_tc     = (tick_q == TICK_W'(OVERSAMPLE - 1));
    assign last_bit   = (bit_q == ({1'b0, cfg_q.wls} + 3'd4));

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        data_d    = data_q;
        cfg_d     = cfg_q;
        ones_d    = ones_q;
        par_err_d = par_err_q;
        rx_prev_d = baud_pulse_i ? rx_s : rx_prev_q;
        push_d    = 1'b0;
        oe_d      = 1'b0;
        dout_d    = dout_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        bi_d      = bi_q;

        if (baud_pulse_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        tick_d  = '0;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_W'(SAMPLE_POINT)) begin
                        tick_d = '0;
                        if (rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            cfg_d     = '{stick: lcr_i.stick_parity, eps: lcr_i.eps,
                                          pen: lcr_i.pen, wls: lcr_i.wls};
                            data_d    = '0;
                            bit_d     = '0;
                            ones_d    = 1'b0;
                            par_err_d = 1'b0;
                            state_d   = ST_DATA;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_tc) begin
                        tick_d         = '0;
                        data_d[bit_q]  = rx_s;
                        ones_d         = ones_q | rx_s;
                        if (last_bit) state_d = cfg_q.pen ? ST_PARITY : ST_STOP;
                        else          bit_d   = bit_q + 3'd1;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_tc) begin
                        tick_d    = '0;
                        ones_d    = ones_q | rx_s;
                        par_err_d = (rx_s != rx_parity(data_q, cfg_q.stick, cfg_q.eps));
                        state_d   = ST_STOP;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_tc) begin
                        tick_d = '0;
                        // An overrun drops the character; the status outputs keep the last pushed one.
                        if (!rx_fifo_full_i) begin
                            push_d = 1'b1;
                            dout_d = data_q;
                            pe_d   = par_err_q;
                            fe_d   = ~rx_s;
                            bi_d   = ~(ones_q | rx_s);
                        end else begin
                            oe_d = 1'b1;
                        end
                        state_d = rx_s ? ST_IDLE : ST_BRK_WAIT;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                ST_BRK_WAIT: begin
                    if (rx_s) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            cfg_q     <= '0;
            ones_q    <= 1'b0;
            par_err_q <= 1'b0;
            rx_prev_q <= 1'b1;
            push_q    <= 1'b0;
            oe_q      <= 1'b0;
            dout_q    <= '0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            cfg_q     <= cfg_d;
            ones_q    <= ones_d;
            par_err_q <= par_err_d;
            rx_prev_q <= rx_prev_d;
            push_q    <= push_d;
            oe_q      <= oe_d;
            dout_q    <= dout_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            bi_q      <= bi_d;
        end
    end

    assign push_o = push_q;
    assign oe_o   = oe_q;
    assign dout_o = dout_q;
    assign pe_o   = pe_q;
    assign fe_o   = fe_q;
    assign bi_o   = bi_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: directed frames plus randomized frames,
// expected characters queued at send time and checked when the DUT pushes or overruns.
module tb_uart_rx_deframer;
    import uart_pkg::*;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud = 1'b0;
    logic       rx = 1'b1;
    logic       full = 1'b0;
    logic [7:0] lcr = 8'h00;

    logic       push_o, pe_o, fe_o, bi_o, oe_o, busy_o;
    logic [7:0] dout_o;

    uart_rx_deframer dut (
        .clk            (clk),
        .rst            (rst),
        .baud_pulse_i   (baud),
        .rx_i           (rx),
        .lcr_i          (lcr),
        .rx_fifo_full_i (full),
        .push_o         (push_o),
        .dout_o         (dout_o),
        .pe_o           (pe_o),
        .fe_o           (fe_o),
        .bi_o           (bi_o),
        .oe_o           (oe_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            baud = 1'b1;
            @(negedge clk);
            baud = 1'b0;
        end
    end

    typedef struct {
        bit         ovr;
        logic [7:0] d;
        bit         pe;
        bit         fe;
        bit         bi;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference character from the serial-line view: what was sent and how the LCR reads it.
    function automatic exp_t model(input logic [7:0] l, input logic [7:0] data,
                                   input bit par, input bit stop, input bit ovr);
        exp_t e;
        int   nb;
        int   ones;
        bit   want;
        nb   = int'(l[1:0]) + 5;
        e.d  = 8'h00;
        for (int i = 0; i < nb; i++) e.d[i] = data[i];
        ones = $countones(e.d);
        if (l[5])      want = !l[4];
        else if (l[4]) want = (ones % 2) == 1;
        else           want = (ones % 2) == 0;
        e.pe  = l[3] && (par != want);
        e.fe  = !stop;
        e.bi  = (e.d == 8'h00) && !stop && (!l[3] || !par);
        e.ovr = ovr;
        return e;
    endfunction

    task automatic send_frame(input logic [7:0] l, input logic [7:0] data, input bit par,
                              input bit stop, input bit full_stop, input bit scramble,
                              input int gap_bits);
        int nb;
        nb = int'(l[1:0]) + 5;
        exp_q.push_back(model(l, data, par, stop, full_stop));
        lcr = l;
        rx  = 1'b0;
        wait_clks(BIT_CLKS);
        check("busy_in_frame", 32'(busy_o), 32'd1);
        if (scramble) lcr = 8'($urandom);
        for (int i = 0; i < nb; i++) begin
            rx = data[i];
            wait_clks(BIT_CLKS);
        end
        if (l[3]) begin
            rx = par;
            wait_clks(BIT_CLKS);
        end
        full = full_stop;
        rx   = stop;
        wait_clks(BIT_CLKS);
        full = 1'b0;
        rx   = 1'b1;
        wait_clks(gap_bits * BIT_CLKS);
    endtask

    always @(negedge clk) begin
        if (rst && (push_o || oe_o)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {29'd0, push_o, oe_o, 1'b0}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("char", {19'd0, push_o, oe_o,
                               push_o ? {dout_o, pe_o, fe_o, bi_o} : 11'd0},
                      {19'd0, !e.ovr, e.ovr,
                       e.ovr ? 11'd0 : {e.d, e.pe, e.fe, e.bi}});
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap;
        bit stp;
        wait_clks(5);
        check("reset_outputs", {21'd0, push_o, oe_o, dout_o, pe_o, fe_o, bi_o, busy_o}, 32'd0);
        rst = 1'b1;
        wait_clks(2 * BIT_CLKS);

        // 8N1 0xA5, then line idle
        send_frame(8'h03, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        check("busy_after_8n1", 32'(busy_o), 32'd0);
        // 8E1 0x07 with wrong parity
        send_frame(8'h1B, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        // 5N1 0x1F with stop 0
        send_frame(8'h00, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        // break for 20 bit times gives one character, then a normal one
        lcr = 8'h03;
        exp_q.push_back(model(8'h03, 8'h00, 1'b0, 1'b0, 1'b0));
        rx = 1'b0;
        wait_clks(20 * BIT_CLKS);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("busy_after_break", 32'(busy_o), 32'd0);
        send_frame(8'h03, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1);

        // glitch shorter than half a bit is a false start
        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        check("busy_false_start", 32'(busy_o), 32'd1);
        wait_clks(2 * BIT_CLKS);
        check("idle_after_false_start", 32'(busy_o), 32'd0);

        // reset in the middle of the data bits of 0x55
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        rx = 1'b0;
        wait_clks(BIT_CLKS / 2);
        check("busy_mid_data", 32'(busy_o), 32'd1);
        rst = 1'b0;
        wait_clks(2);
        check("outputs_in_reset", {21'd0, push_o, oe_o, dout_o, pe_o, fe_o, bi_o, busy_o}, 32'd0);
        rx = 1'b1;
        wait_clks(3);
        rst = 1'b1;
        wait_clks(12 * BIT_CLKS);
        check("idle_after_reset", 32'(busy_o), 32'd0);

        // overrun on 0x81, then back-to-back 0x81, 0x42
        send_frame(8'h03, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        send_frame(8'h03, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h03, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0, 1);

        for (int n = 0; n < 30; n++) begin
            stp = ($urandom_range(0, 3) != 0);
            gap = stp ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send_frame(8'($urandom), 8'($urandom), 1'($urandom), stp,
                       ($urandom_range(0, 4) == 0), 1'b1, gap);
        end

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) wait_clks(1);
        check("all_chars_seen", 32'(exp_q.size()), 32'd0);
        wait_clks(2 * BIT_CLKS);
        check("final_idle", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
